fetch_controller: RTL

Sequences the word-indexed instruction memory for the MIPS core: holds the byte PC, drives the memory's word index, and streams fetched words with their PC into a 2-entry buffer toward decode over a valid/ready handshake. It sits between `instruction_memory` and the decode stage. It also handles branch/jump redirects (flush plus new PC), start/stop via `run`, and a halt-instruction stop.

---
 rtl/fetch_controller_if.sv | 19 +
 rtl/fetch_controller.sv | 66 ++++++
 2 files changed

// File: rtl/fetch_controller_if.sv
// fetch_controller_if: memory, redirect and decode handshake signals of the fetch controller.
interface fetch_controller_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  modport master (
    output imem_addr, inst_valid, inst, inst_pc,
    input  imem_data, redirect_valid, redirect_pc, inst_ready
  );
  modport slave (
    input  imem_addr, inst_valid, inst, inst_pc,
    output imem_data, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_controller.sv
// fetch_controller: PC sequencer streaming fetched words into a 2-entry buffer toward decode.
// Optional FETCH_BOUNDS_CHECK_EN halts with fault on out-of-range fetch.
module fetch_controller #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] IMEM_DEPTH = 32,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  fetch_controller_if.master bus,
  output logic halted,
  output logic fault
);
  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;
  state_t state, nxt;
  logic [31:0] pc;
  logic [31:0] d [2];
  logic [31:0] p [2];
  logic [1:0] count;
  logic rd, wr, deq, space, active, oob, hit, enq;
  assign bus.imem_addr  = {2'b00, pc[31:2]};
  assign bus.inst_valid = count != 2'd0;
  assign bus.inst       = d[rd];
  assign bus.inst_pc    = p[rd];
  assign deq    = bus.inst_valid && bus.inst_ready;
  assign space  = !count[1] || deq;
  assign wr     = rd ^ count[0];
  // Fetch follows run directly so the first word issues in the cycle run rises.
  assign active = run && state != HALT && space && !bus.redirect_valid;
`ifdef FETCH_BOUNDS_CHECK_EN
  assign oob = bus.imem_addr >= IMEM_DEPTH;
`else
  assign oob = 1'b0;
`endif
  assign hit = active && !oob && bus.imem_data == HALT_WORD;
  assign enq = active && !oob && !hit;
  always_comb
    nxt = bus.redirect_valid ? (run ? FETCH : IDLE) :
          state == HALT ? HALT :
          (active && (oob || hit)) ? HALT :
          run ? FETCH : IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      halted <= 1'b0;
      fault  <= 1'b0;
      pc     <= RESET_PC;
      count  <= 2'd0;
      rd     <= 1'b0;
      d      <= '{32'h0, 32'h0};
      p      <= '{32'h0, 32'h0};
    end else begin
      state  <= nxt;
      halted <= nxt == HALT;
      fault  <= bus.redirect_valid ? 1'b0 : fault | (active && oob);
      rd     <= rd ^ deq;
      count  <= bus.redirect_valid ? 2'd0 : count + 2'(enq) - 2'(deq);
      pc     <= bus.redirect_valid ? (bus.redirect_pc & 32'hFFFF_FFFC) : enq ? pc + 32'd4 : pc;
      if (enq) begin
        d[wr] <= bus.imem_data;
        p[wr] <= pc;
      end
    end
  end
endmodule
